// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning 2^N one-cold decoder.
package dec_pkg;

    localparam int MAX_N = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Index to one-cold vector at the widest legal size; callers truncate.
    function automatic logic [63:0] one_cold(input logic [MAX_N-1:0] i);
        return ~(64'd1 << i);
    endfunction

endpackage

// File: rtl/dec_dwell_ctr.sv
// Dwell counter: clears, freezes, or steps; done flags that the index may advance.
module dec_dwell_ctr
    import dec_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               done
);

    logic [DWELL_W-1:0] cnt_r;

    // Compare against the live dwell so a shrink takes effect at once.
    assign done = (cnt_r >= dwell);

    // Count register: step wraps to zero when done, otherwise holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {DWELL_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {DWELL_W{1'b0}};
        end else if (step) begin
            if (done) begin
                cnt_r <= {DWELL_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + DWELL_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// 3-to-8 style gated decoder (2^N outputs, active low) with an auto-scan mode.
module dec_scan
    import dec_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        sel,
    input  logic                g1,
    input  logic                g2a_l,
    input  logic                g2b_l,
    input  logic                mode,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [(1<<N)-1:0]   y_l,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int W = 1 << N;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           en_s;
    logic           resume_s;
    logic           cnt_clear_s;
    logic           cnt_done_s;
    logic           advance_s;
    logic           lit_s;
    logic [N-1:0]   idx_nxt_s;
    logic           wrap_nxt_s;
    logic [W-1:0]   y_nxt_s;

    assign en_s = g1 & ~g2a_l & ~g2b_l;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a dropped enable takes priority over a mode change.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_s) state_nxt_s = mode ? SCAN : DIRECT;
                else      state_nxt_s = IDLE;
            end
            DIRECT: begin
                if (!en_s)     state_nxt_s = IDLE;
                else if (mode) state_nxt_s = SCAN;
                else           state_nxt_s = DIRECT;
            end
            SCAN: begin
                if (!en_s)      state_nxt_s = HOLD;
                else if (!mode) state_nxt_s = DIRECT;
                else            state_nxt_s = SCAN;
            end
            HOLD: begin
                if (en_s) state_nxt_s = mode ? SCAN : DIRECT;
                else      state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // A scan continues (rather than restarts) only from SCAN or a paused HOLD.
    assign resume_s    = (state_nxt_s == SCAN) && ((state_r == SCAN) || (state_r == HOLD));
    assign cnt_clear_s = (state_nxt_s == IDLE) || (state_nxt_s == DIRECT) ||
                         ((state_nxt_s == SCAN) && !resume_s);
    assign advance_s   = resume_s & cnt_done_s;

    dec_dwell_ctr #(.DWELL_W(DWELL_W)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_s),
        .step  (resume_s),
        .dwell (dwell),
        .done  (cnt_done_s)
    );

    // Output logic: values the registers take at the coming edge.
    always_comb begin
        idx_nxt_s  = idx;
        wrap_nxt_s = 1'b0;
        lit_s      = 1'b0;
        case (state_nxt_s)
            DIRECT: begin
                idx_nxt_s = sel;
                lit_s     = 1'b1;
            end
            SCAN: begin
                lit_s = 1'b1;
                if (!resume_s) begin
                    idx_nxt_s = {N{1'b0}};
                end else if (advance_s) begin
                    idx_nxt_s  = idx + N'(1);
                    wrap_nxt_s = (idx == {N{1'b1}});
                end else begin
                    idx_nxt_s = idx;
                end
            end
            default: begin
                idx_nxt_s = idx;
                lit_s     = 1'b0;
            end
        endcase
        if (lit_s) begin
            y_nxt_s = W'(one_cold(MAX_N'(idx_nxt_s)));
        end else begin
            y_nxt_s = {W{1'b1}};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_l  <= {W{1'b1}};
            idx  <= {N{1'b0}};
            wrap <= 1'b0;
        end else begin
            y_l  <= y_nxt_s;
            idx  <= idx_nxt_s;
            wrap <= wrap_nxt_s;
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan at N=3, DWELL_W=8.
module tb_dec_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       g1;
    logic       g2a_l;
    logic       g2b_l;
    logic       mode;
    logic [7:0] dwell;
    logic [7:0] y_l;
    logic [2:0] idx;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    logic [7:0] yt [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #5 clk = ~clk;

    dec_scan #(.N(3), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .g1    (g1),
        .g2a_l (g2a_l),
        .g2b_l (g2b_l),
        .mode  (mode),
        .dwell (dwell),
        .y_l   (y_l),
        .idx   (idx),
        .wrap  (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; g1 = 1'b1; g2a_l = 1'b0; g2b_l = 1'b0;
        mode = 1'b0; sel = 3'd3; dwell = 8'd0;
        tick();
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dominates got y_l=%h idx=%0d wrap=%b want FF 0 0", y_l, idx, wrap);
        end
    endtask

    task automatic test_direct();
        rst = 1'b0; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            checks++;
            if ({y_l, idx, wrap} !== {yt[s], 3'(s), 1'b0}) begin
                errors++;
                $display("FAIL direct_sel%0d got y_l=%h idx=%0d wrap=%b want %h %0d 0", s, y_l, idx, wrap, yt[s], s);
            end
        end
        g2a_l = 1'b1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd7, 1'b0}) begin
            errors++;
            $display("FAIL direct_g2a_off got y_l=%h idx=%0d wrap=%b want FF 7 0", y_l, idx, wrap);
        end
        g2a_l = 1'b0; g2b_l = 1'b1; sel = 3'd2;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd7, 1'b0}) begin
            errors++;
            $display("FAIL direct_g2b_off got y_l=%h idx=%0d wrap=%b want FF 7 0", y_l, idx, wrap);
        end
        g2b_l = 1'b0;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFB, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL direct_reenable got y_l=%h idx=%0d wrap=%b want FB 2 0", y_l, idx, wrap);
        end
        g1 = 1'b0;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL direct_g1_off got y_l=%h idx=%0d wrap=%b want FF 2 0", y_l, idx, wrap);
        end
    endtask

    task automatic test_scan_dwell2();
        dwell = 8'd2; mode = 1'b1; g1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 3; r++) begin
                tick();
                checks++;
                if ({y_l, idx, wrap} !== {yt[k], 3'(k), 1'b0}) begin
                    errors++;
                    $display("FAIL scan2_idx%0d_rep%0d got y_l=%h idx=%0d wrap=%b want %h %0d 0", k, r, y_l, idx, wrap, yt[k], k);
                end
            end
        end
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL scan2_wrap got y_l=%h idx=%0d wrap=%b want FE 0 1", y_l, idx, wrap);
        end
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL scan2_wrap_end got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
    endtask

    task automatic test_scan_dwell0();
        logic [2:0] ei;
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 8'd0;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL scan0_entry got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            ei = 3'(c);
            checks++;
            if ({y_l, idx, wrap} !== {yt[ei], ei, (ei == 3'd0)}) begin
                errors++;
                $display("FAIL scan0_cycle%0d got y_l=%h idx=%0d wrap=%b want %h %0d %b", c, y_l, idx, wrap, yt[ei], ei, (ei == 3'd0));
            end
        end
    endtask

    task automatic test_pause_resume();
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 8'd3;
        tick();
        repeat (16) tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hEF, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL pause_reach_idx4 got y_l=%h idx=%0d wrap=%b want EF 4 0", y_l, idx, wrap);
        end
        tick();
        g1 = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++;
            if ({y_l, idx, wrap} !== {8'hFF, 3'd4, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold%0d got y_l=%h idx=%0d wrap=%b want FF 4 0", h, y_l, idx, wrap);
            end
        end
        g1 = 1'b1;
        for (int h = 0; h < 2; h++) begin
            tick();
            checks++;
            if ({y_l, idx, wrap} !== {8'hEF, 3'd4, 1'b0}) begin
                errors++;
                $display("FAIL resume_idx4_%0d got y_l=%h idx=%0d wrap=%b want EF 4 0", h, y_l, idx, wrap);
            end
        end
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hDF, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL resume_advance got y_l=%h idx=%0d wrap=%b want DF 5 0", y_l, idx, wrap);
        end
    endtask

    task automatic test_dwell_shrink_mode();
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 8'd10;
        tick();
        repeat (5) tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL shrink_before got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
        dwell = 8'd1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFD, 3'd1, 1'b0}) begin
            errors++;
            $display("FAIL shrink_advance got y_l=%h idx=%0d wrap=%b want FD 1 0", y_l, idx, wrap);
        end
        tick();
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFB, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL shrink_dwell1 got y_l=%h idx=%0d wrap=%b want FB 2 0", y_l, idx, wrap);
        end
        mode = 1'b0; sel = 3'd6;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hBF, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL mode_to_direct got y_l=%h idx=%0d wrap=%b want BF 6 0", y_l, idx, wrap);
        end
        mode = 1'b1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL mode_back_restart got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
    endtask

    task automatic test_reset_mid_scan();
        dwell = 8'd0;
        repeat (5) tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hDF, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL rst_reach_idx5 got y_l=%h idx=%0d wrap=%b want DF 5 0", y_l, idx, wrap);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_scan got y_l=%h idx=%0d wrap=%b want FF 0 0", y_l, idx, wrap);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_release_scan got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
        tick();
        tick();
        g1 = 1'b0;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL rst_hold_entry got y_l=%h idx=%0d wrap=%b want FF 2 0", y_l, idx, wrap);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_in_hold got y_l=%h idx=%0d wrap=%b want FF 0 0", y_l, idx, wrap);
        end
        rst = 1'b0; g1 = 1'b1;
        tick();
        checks++;
        if ({y_l, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_hold_no_resume got y_l=%h idx=%0d wrap=%b want FE 0 0", y_l, idx, wrap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_direct();
        test_scan_dwell2();
        test_scan_dwell0();
        test_pause_resume();
        test_dwell_shrink_mode();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter: N, 3, select width; output width is 2^N; legal range 1..6.
REQ-002 Parameter: DWELL_W, 8, width of the dwell count.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: sel  input  N  direct-mode select code.
REQ-006 Port: g1  input  1  active-high enable.
REQ-007 Port: g2a_l  input  1  active-low enable.
REQ-008 Port: g2b_l  input  1  active-low enable.
REQ-009 Port: mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-010 Port: dwell  input  DWELL_W  scan mode: extra cycles each index is held.
REQ-011 Port: y_l  output  2^N  registered one-cold decode; all ones when inactive.
REQ-012 Port: idx  output  N  index currently driven on y_l.
REQ-013 Port: wrap  output  1  one-cycle pulse when the scan index wraps to 0.

Function
REQ-014 en SHALL be g1 AND NOT g2a_l AND NOT g2b_l.
REQ-015 All outputs SHALL be registered, so y_l, idx and wrap reflect the inputs sampled at the previous edge (1-cycle latency).
REQ-016 The FSM SHALL have the states IDLE, DIRECT, SCAN and HOLD.
REQ-017 IDLE: en=1 with mode=0 goes to DIRECT; en=1 with mode=1 goes to SCAN with the scan index and dwell count cleared to 0.
REQ-018 DIRECT: en=0 goes to IDLE; mode=1 goes to SCAN with the index and dwell count cleared.
REQ-019 SCAN: en=0 goes to HOLD with the index and dwell count frozen; mode=0 goes to DIRECT with the index and dwell count cleared.
REQ-020 HOLD: en=1 with mode=1 returns to SCAN and resumes the frozen index and count; en=1 with mode=0 goes to DIRECT with both cleared.
REQ-021 In DIRECT, the edge SHALL load y_l with bit sel low and all other bits high, and load idx with sel.
REQ-022 In IDLE or HOLD, y_l SHALL be all ones; idx SHALL hold its last value.
REQ-023 In SCAN, y_l SHALL drive bit idx low; the dwell count SHALL increment each cycle; once count >= dwell, the next edge advances idx by 1 (mod 2^N) and clears the count.
REQ-024 Each index SHALL therefore be held for dwell+1 cycles; dwell=0 advances every cycle.
REQ-025 A change of dwell during a scan SHALL apply immediately through the >= compare; a value below the current count forces an advance on the next edge.
REQ-026 An advance from 2^N-1 to 0 SHALL assert wrap for exactly the cycle in which y_l first shows index 0; wrap SHALL be 0 otherwise, including in HOLD.
REQ-027 The first index 0 after entry to SCAN SHALL NOT assert wrap.
REQ-028 The first SCAN cycle after entry SHALL drive index 0 on y_l.
REQ-029 y_l SHALL never have more than one bit low in any cycle.

Reset
REQ-030 rst=1 at an edge SHALL set y_l to all ones, idx to 0, wrap to 0, state to IDLE and the dwell count to 0.
REQ-031 rst SHALL dominate all other inputs, including in mid-scan and in HOLD.
REQ-032 After rst is released, the first enabled edge SHALL follow REQ-017.

Structure
REQ-033 The state enum and a one-cold function (index to 2^N vector) SHALL reside in the shared package dec_pkg.
REQ-034 The dwell counter, including its compare and clear/freeze controls, SHALL be the single sub-module dec_dwell_ctr.
REQ-035 The target implementation size SHALL be 120-400 lines of RTL in total.

Verification (N=3, DWELL_W=8)
REQ-036 Reset check: assert rst during a scan at idx=5 -> the next cycle shows y_l=8'hFF, idx=0, wrap=0, state IDLE.
REQ-037 Direct mode: mode=0, enabled, sel 0..7 -> one cycle later y_l is 8'hFE, FD, FB, F7, EF, DF, BF, 7F in turn; setting g2a_l=1 gives 8'hFF on the next cycle.
REQ-038 Scan with dwell=2: each y_l value holds 3 cycles; idx runs 0..7 then 0; wrap is high only on the first cycle of the second idx=0.
REQ-039 Scan with dwell=0: idx advances every cycle; wrap pulses every 8 cycles.
REQ-040 Pause and resume: drop g1 at idx=4 with count=1 -> y_l=8'hFF and wrap=0 while disabled; restore g1 -> idx=4 resumes and holds for the remaining dwell-1 cycles.
REQ-041 Dwell shrink and mode switch: change dwell from 10 to 1 at count=5 -> advance on the next edge; switch mode to 0 mid-scan -> y_l follows sel next cycle, and a later return to SCAN restarts at idx=0.
